// File: rtl/tetris_pkg.sv
// Shared playfield geometry, grid types and line-clear FSM encoding.
// Everything downstream of lock imports this package.
package tetris_pkg;

    localparam int unsigned ROWS  = 22;
    localparam int unsigned COLS  = 10;
    localparam int unsigned CW    = 3;

    // Row pointers need one extra (sign) bit so they can reach -1.
    localparam int unsigned PTR_W = $clog2(ROWS) + 1;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned TOT_W = 16;

    typedef logic [CW-1:0]     cell_t;
    typedef cell_t [COLS-1:0]  row_t;
    typedef row_t  [ROWS-1:0]  grid_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FILL,
        DONE
    } lc_state_t;

    // Running total plus one pass's count, clamped at all-ones.
    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [TOT_W:0] sum;
        sum = {1'b0, a} + {{(TOT_W + 1 - CNT_W){1'b0}}, b};
        return sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
    endfunction

endpackage

// File: rtl/line_clear_if.sv
// Request/result bundle between the game controller and the line-clear stage.
// The controller side is master; line_clear is slave.
interface line_clear_if;
    import tetris_pkg::*;

    logic               start;
    grid_t              grid_in;
    logic               busy;
    logic               done;
    grid_t              grid_out;
    logic [CNT_W-1:0]   lines_cleared;
    logic [TOT_W-1:0]   total_lines;

    modport master (
        output start,
        output grid_in,
        input  busy,
        input  done,
        input  grid_out,
        input  lines_cleared,
        input  total_lines
    );

    modport slave (
        input  start,
        input  grid_in,
        output busy,
        output done,
        output grid_out,
        output lines_cleared,
        output total_lines
    );

endinterface

// File: rtl/row_full.sv
// Combinational full-row detect: a row is full when every cell is non-empty.
module row_full
    import tetris_pkg::*;
(
    input  row_t i_row,
    output logic o_full
);

    logic [COLS-1:0] w_cell_nz;

    always_comb begin
        w_cell_nz = '0;
        for (int c = 0; c < COLS; c++) begin
            w_cell_nz[c] = |i_row[c];
        end
    end

    assign o_full = &w_cell_nz;

endmodule

// File: rtl/line_clear.sv
// Removes full rows from a locked playfield, compacts the rest downward and
// zero-fills the top; fixed latency of ROWS+1 cycles from start to done.
module line_clear
    import tetris_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    line_clear_if.slave  bus
);

    lc_state_t                 r_state;
    lc_state_t                 w_state_nxt;

    grid_t                     r_work;
    grid_t                     w_filled;
    logic signed [PTR_W-1:0]   r_rd;
    logic signed [PTR_W-1:0]   r_wr;
    logic [CNT_W-1:0]          r_cnt;

    logic                      r_busy;
    logic                      r_done;
    grid_t                     r_grid_out;
    logic [CNT_W-1:0]          r_lines;
    logic [TOT_W-1:0]          r_total;

    logic [PTR_W-2:0]          w_rd_idx;
    logic [PTR_W-2:0]          w_wr_idx;
    row_t                      w_rd_row;
    logic                      w_row_full;

    // Both pointers are non-negative whenever they are used as indices in SCAN.
    assign w_rd_idx = r_rd[PTR_W-2:0];
    assign w_wr_idx = r_wr[PTR_W-2:0];
    assign w_rd_row = r_work[w_rd_idx];

    row_full u_row_full (
        .i_row  (w_rd_row),
        .o_full (w_row_full)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SCAN;
            SCAN:    if (r_rd == '0) w_state_nxt = FILL;
            FILL:    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Rows 0..wr were never written by compaction; wr = -1 zeroes nothing.
    always_comb begin
        w_filled = r_work;
        for (int r = 0; r < ROWS; r++) begin
            if (r <= int'(r_wr)) begin
                w_filled[r] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_work     <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_grid_out <= '0;
            r_lines    <= '0;
            r_total    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_work <= bus.grid_in;
                        r_rd   <= PTR_W'(ROWS - 1);
                        r_wr   <= PTR_W'(ROWS - 1);
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    // wr >= rd always, so copying down in place never clobbers unread rows.
                    if (w_row_full) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_work[w_wr_idx] <= w_rd_row;
                        r_wr             <= r_wr - PTR_W'(1);
                    end
                    r_rd <= r_rd - PTR_W'(1);
                end
                FILL: begin
                    r_work     <= w_filled;
                    r_grid_out <= w_filled;
                    r_lines    <= r_cnt;
                    r_total    <= sat_add(r_total, r_cnt);
                    r_done     <= 1'b1;
                end
                DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.grid_out      = r_grid_out;
    assign bus.lines_cleared = r_lines;
    assign bus.total_lines   = r_total;

    a_done_in_busy : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_done |-> r_busy);

    a_wr_ge_rd : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == SCAN) |-> (r_wr >= r_rd));

    a_busy_tracks_state : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_busy == (r_state != IDLE));

endmodule

// File: doc/line_clear.md
# line_clear

Line-clear stage downstream of the horizontal-move and lock logic. When a piece locks, the merged 22×10 playfield is handed to this block. It removes every completely filled row, compacts the remaining rows toward the bottom, and zero-fills the top. It then returns the cleaned stack and the number of lines removed to the game controller for scoring and the next spawn.

## Interface
Parameters:
- ROWS, 22, playfield rows; row 0 is the top, row ROWS-1 is the bottom.
- COLS, 10, playfield columns.
- CW, 3, cell colour width; 0 means empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-low (asserted at 0).
- start  in  1  one-cycle request; sampled only in IDLE.
- grid_in  in  [ROWS][COLS][CW]  locked playfield; captured on the start edge.
- busy  out  1  high while state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- grid_out  out  [ROWS][COLS][CW]  last completed result; held between passes.
- lines_cleared  out  5  full rows removed in the last pass (0..ROWS).
- total_lines  out  16  running sum of lines_cleared; saturates at 16'hFFFF.

## Operation
- States: IDLE, SCAN, FILL, DONE.
- IDLE:
  - On start=1, copy grid_in into the internal work grid.
  - Set rd = wr = ROWS-1 and cnt = 0, then go to SCAN.
- SCAN processes one row per cycle, at row rd:
  - A row is full when all COLS cells are ≠ 0.
  - Full row: cnt++ and rd--; wr is unchanged.
  - Not full: work[wr] ← work[rd], then wr-- and rd--. Because wr ≥ rd, the in-place copy is safe.
  - After the cycle that processes rd=0, go to FILL.
- FILL (one cycle):
  - Rows 0..wr are zeroed. No rows are zeroed if wr = -1.
  - grid_out ← the resulting grid, lines_cleared ← cnt.
  - total_lines ← min(total_lines + cnt, 16'hFFFF).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Widths:
  - rd and wr are $clog2(ROWS)+1 bits, signed, so that -1 is representable.
  - cnt is 5 bits.
  - The total_lines addition is 17 bits, then clamped.
- start in SCAN, FILL or DONE is ignored and not queued.
- grid_in changes after the start edge have no effect on the pass in progress.
- Reset clears everything regardless of state, including mid-SCAN:
  - state ← IDLE.
  - busy, done ← 0.
  - grid_out ← all zero.
  - lines_cleared ← 0, total_lines ← 0.
  - The work grid and pointers are cleared; the pass in progress is discarded.

## Timing
- Edge E0 samples start.
- Edges E1..E_ROWS run SCAN.
- Edge E_ROWS+1 runs FILL and updates the outputs.
- done is high in the cycle after E_ROWS+1: 23 cycles after E0 with ROWS=22.
- Fixed latency, independent of grid contents.
- busy is high from the cycle after E0 through the done cycle, inclusive.
- The earliest next accepted start is at the edge ending the done cycle + 1, i.e. in IDLE.
- grid_out, lines_cleared and total_lines change only at the FILL edge and are stable while done=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package tetris_pkg holds:
  - ROWS, COLS, CW constants.
  - typedef cell_t (logic [CW-1:0]).
  - typedef row_t (cell_t [COLS-1:0]).
  - typedef grid_t (row_t [ROWS-1:0]).
  - enum lc_state_t {IDLE, SCAN, FILL, DONE}.
- One sub-module, row_full: combinational, row_t in, 1-bit full out (AND of per-cell OR-reductions), applied to work[rd].
- The FSM, pointers and counters live in line_clear.

## Test plan
- Empty grid, start → done exactly 23 cycles after the start edge; grid_out all 0; lines_cleared=0; total_lines=0.
- Row 21 all colour 1, row 20 col 4 = 2 → grid_out row 21 col 4 = 2, all else 0; lines_cleared=1; total_lines=1.
- Rows 21 and 19 full; row 20 col 0 = 3; row 18 col 9 = 5 → row 21 col 0 = 3, row 20 col 9 = 5, rows 0..19 zero; lines_cleared=2; total_lines accumulates to 3.
- All 22 rows full → grid_out all 0, lines_cleared=22.
- Start pulsed during SCAN and during DONE → ignored; one done per accepted start; grid_in changes mid-pass do not alter the result.
- Reset asserted at cycle 10 of SCAN → busy=0, done=0, grid_out=0, total_lines=0 immediately; a new start after release completes normally in 23 cycles.
